// File: rtl/serial_parity_frame_rx.sv
// Serial frame receiver: start bit, DATA_WIDTH data bits LSB first, parity bit, stop bit.
// Presents the captured word and parity bit with a one-cycle valid strobe; flags bad stop bits.
module serial_parity_frame_rx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  serial_in,
  input  logic                  bit_valid,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  parity_out,
  output logic                  frame_valid,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int CW = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic [DATA_WIDTH-1:0] shreg, shreg_nxt;
  logic                  par_reg, par_reg_nxt;
  logic [DATA_WIDTH-1:0] data_out_nxt;
  logic                  parity_out_nxt;
  logic                  frame_valid_nxt;
  logic                  frame_err_nxt;
  logic                  busy_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      shreg       <= '0;
      par_reg     <= 1'b0;
      data_out    <= '0;
      parity_out  <= 1'b0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      shreg       <= shreg_nxt;
      par_reg     <= par_reg_nxt;
      data_out    <= data_out_nxt;
      parity_out  <= parity_out_nxt;
      frame_valid <= frame_valid_nxt;
      frame_err   <= frame_err_nxt;
      busy        <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    shreg_nxt       = shreg;
    par_reg_nxt     = par_reg;
    data_out_nxt    = data_out;
    parity_out_nxt  = parity_out;
    frame_valid_nxt = 1'b0;
    frame_err_nxt   = 1'b0;

    if (bit_valid) begin
      case (state)
        IDLE: begin
          if (!serial_in) begin
            cnt_nxt   = '0;
            state_nxt = DATA;
          end
        end
        DATA: begin
          // Shift right so the first data bit ends up in bit 0 (also valid for width 1).
          shreg_nxt                 = shreg >> 1;
          shreg_nxt[DATA_WIDTH-1]   = serial_in;
          cnt_nxt                   = cnt + 1'b1;
          if (cnt == CW'(DATA_WIDTH - 1)) begin
            state_nxt = PARITY;
          end
        end
        PARITY: begin
          par_reg_nxt = serial_in;
          state_nxt   = STOP;
        end
        STOP: begin
          if (serial_in) begin
            data_out_nxt    = shreg;
            parity_out_nxt  = par_reg;
            frame_valid_nxt = 1'b1;
          end else begin
            frame_err_nxt   = 1'b1;
          end
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end

    busy_nxt = (state_nxt != IDLE);
  end

endmodule
